i2c_req_arbiter: RTL and testbench
==================================

Name: i2c_req_arbiter

Overview:
Shares the single I2C master between NUM_REQ client requesters. Round-robin arbitration picks one client per transaction. The block launches the transaction on the master and holds addr/rw/data_in stable until done. It routes the result or a timeout back to the owning client. It sits directly above the I2C master in the top level, and the master's START-to-done window is driven only by this block.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
TIMEOUT_CYCLES, 64, cycles in WAIT without m_done before the transaction is aborted with timeout
ADDR_W, 7, I2C slave address width (fixed by protocol)
DATA_W, 8, data byte width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-client request pending
req_ready  out  NUM_REQ  per-client accept strobe (one-hot or zero)
req_addr  in  NUM_REQ*ADDR_W  packed client addresses, client i at [i*7 +: 7]
req_rw  in  NUM_REQ  per-client direction, 1 = write, 0 = read
req_data  in  NUM_REQ*DATA_W  packed client write bytes
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning client
rsp_data  out  DATA_W  read byte; 8'h00 for writes and timeouts
rsp_timeout  out  1  qualifies rsp_valid: transaction aborted by watchdog
m_start  out  1  one-cycle launch pulse to the I2C master
m_addr  out  ADDR_W  address to master, held through WAIT
m_rw  out  1  direction to master, held through WAIT
m_data_in  out  DATA_W  write byte to master, held through WAIT
m_data_out  in  DATA_W  read byte from master
m_done  in  1  master completion

Behaviour:
- Reset (rst=1 at a clk edge, including mid-transaction):
  - state becomes ARB_IDLE; all outputs go to 0; watchdog clears.
  - Round-robin pointer last_grant is set to NUM_REQ-1, so client 0 has first priority.
  - No rsp_valid is issued for an aborted transaction.
- States: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP.
- ARB_IDLE:
  - The grant is the first asserted req_valid searching from last_grant+1 upward, with wrap-around modulo NUM_REQ.
  - req_ready[grant] is combinationally 1 in this state only, and only if any req_valid is set.
  - On handshake: latch owner, addr, rw and data into holding registers; go to ARB_ISSUE.
  - With no requests, stay in IDLE.
- ARB_ISSUE: m_start=1 for exactly this cycle. m_addr/m_rw/m_data_in already show the latched values. Go to ARB_WAIT next cycle.
- ARB_WAIT:
  - m_addr/m_rw/m_data_in are held constant.
  - The watchdog counter starts at 0 and increments each cycle.
  - m_done=1: capture m_data_out if rw=0 (else capture 0x00), timeout=0, go to ARB_RESP.
  - Counter reaching TIMEOUT_CYCLES-1 with no m_done: timeout=1, data 0x00, go to ARB_RESP.
  - m_done and expiry in the same cycle: m_done wins (no timeout).
- ARB_RESP:
  - rsp_valid[owner]=1 for one cycle, with rsp_data and rsp_timeout valid in that same cycle.
  - last_grant <= owner; go to ARB_IDLE.
  - A new grant is possible on the very next cycle.
- m_done outside ARB_WAIT is ignored.
- req_valid deassertion after accept has no effect on the transaction.
- Latency: handshake at cycle T, m_start at T+1, m_done sampled at cycle D gives rsp_valid at D+1.
- Minimum gap between two m_start pulses is 4 cycles plus the master's own transaction time.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transactions.
- m_* outputs retain the last latched values while IDLE; the master must not act without m_start.

Decomposition:
- Package i2c_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}
  - localparams I2C_ADDR_W=7 and I2C_DATA_W=8
  - RSP_WRITE_DATA = 8'h00
- One sub-module: rr_arbiter, parameterised by NUM_REQ. It takes req_valid and last_grant and produces a one-hot grant plus an index, purely combinationally. Pointer storage stays in i2c_req_arbiter.

Test Plan:
- Single write: client 1 sends addr=7'h2A, rw=1, data=8'hA5. Expect req_ready[1] in the same cycle and m_start one cycle later. m_addr=2A, m_rw=1 and m_data_in=A5 stay stable until m_done. Then rsp_valid[1] one cycle after m_done, with rsp_data=00 and rsp_timeout=0.
- Single read: client 0 sends addr=7'h11, rw=0, and the master returns m_data_out=8'h3C with m_done. Expect rsp_valid[0] with rsp_data=3C.
- Round-robin: all 4 clients request continuously from reset. Expect grant order 0,1,2,3,0, each with exactly one m_start per transaction.
- Timeout: a request is accepted but m_done is never asserted. Expect rsp_valid with rsp_timeout=1 and rsp_data=00 exactly 64 cycles after entering WAIT, then IDLE. Separately, m_done asserted on the expiry cycle must give rsp_timeout=0.
- Reset mid-transaction: assert rst for 1 cycle during WAIT. Expect no rsp_valid, m_start=0, and client 0 granted first after reset even if client 2 was the owner.
- Spurious done: m_done pulses while IDLE and during ISSUE. Expect no state change and no rsp_valid.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_arb_pkg;

  // Transaction sequencing states of the arbiter.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  // Byte returned to a client for writes and for watchdog aborts.
  localparam logic [7:0] RSP_WRITE_DATA = 8'h00;

endpackage

// File: rtl/i2c_req_arbiter_rr.sv
// Combinational round-robin selector: first asserted request strictly after
// last_grant, wrapping modulo NUM_REQ. Holds no state.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand_s;

  // Scan candidates in priority order starting just after the previous owner.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(last_grant) + 1 + i) % NUM_REQ);
      if (!grant_valid && req_valid[cand_s]) begin
        grant_valid      = 1'b1;
        grant_idx        = cand_s;
        grant[cand_s]    = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master among NUM_REQ clients: round-robin accept, launch,
// hold the command through the master's busy window, and return the result
// (or a watchdog timeout) to the owning client.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = I2C_ADDR_W,
  parameter int DATA_W         = I2C_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_timeout,
  output logic                      m_start,
  output logic [ADDR_W-1:0]         m_addr,
  output logic                      m_rw,
  output logic [DATA_W-1:0]         m_data_in,
  input  logic [DATA_W-1:0]         m_data_out,
  input  logic                      m_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_t          state_r;
  logic [IDX_W-1:0]    last_grant_r;
  logic [IDX_W-1:0]    owner_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                rw_r;
  logic [DATA_W-1:0]   data_r;
  logic [WD_W-1:0]     wdog_r;
  logic                m_start_r;
  logic [NUM_REQ-1:0]  rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_timeout_r;

  logic [NUM_REQ-1:0]  grant_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                grant_valid_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_valid   (req_valid),
    .last_grant  (last_grant_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Accept strobe is only offered while idle; the grant is already zero
  // when nobody is requesting.
  always_comb begin
    if (state_r == ARB_IDLE) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Transaction sequencer with registered master and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ARB_IDLE;
      last_grant_r  <= IDX_W'(NUM_REQ - 1);
      owner_r       <= '0;
      addr_r        <= '0;
      rw_r          <= 1'b0;
      data_r        <= '0;
      wdog_r        <= '0;
      m_start_r     <= 1'b0;
      rsp_valid_r   <= '0;
      rsp_data_r    <= '0;
      rsp_timeout_r <= 1'b0;
    end else begin
      m_start_r   <= 1'b0;
      rsp_valid_r <= '0;
      case (state_r)
        ARB_IDLE: begin
          if (grant_valid_s) begin
            owner_r   <= grant_idx_s;
            addr_r    <= req_addr[grant_idx_s*ADDR_W +: ADDR_W];
            rw_r      <= req_rw[grant_idx_s];
            data_r    <= req_data[grant_idx_s*DATA_W +: DATA_W];
            m_start_r <= 1'b1;
            state_r   <= ARB_ISSUE;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_ISSUE: begin
          wdog_r  <= '0;
          state_r <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // Completion takes precedence over a simultaneous watchdog expiry.
          if (m_done) begin
            rsp_data_r    <= rw_r ? DATA_W'(RSP_WRITE_DATA) : m_data_out;
            rsp_timeout_r <= 1'b0;
            rsp_valid_r   <= ONE_HOT0 << owner_r;
            state_r       <= ARB_RESP;
          end else if (wdog_r == WD_LAST) begin
            rsp_data_r    <= DATA_W'(RSP_WRITE_DATA);
            rsp_timeout_r <= 1'b1;
            rsp_valid_r   <= ONE_HOT0 << owner_r;
            state_r       <= ARB_RESP;
          end else begin
            wdog_r <= wdog_r + WD_W'(1);
          end
        end
        ARB_RESP: begin
          last_grant_r  <= owner_r;
          rsp_data_r    <= '0;
          rsp_timeout_r <= 1'b0;
          state_r       <= ARB_IDLE;
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  assign m_start     = m_start_r;
  assign m_addr      = addr_r;
  assign m_rw        = rw_r;
  assign m_data_in   = data_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a table of single transactions plus
// hand-written sequences for timeout, reset and spurious-done corners.
module tb_i2c_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [27:0] req_addr = '0;
  logic [3:0]  req_rw = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_timeout;
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic [7:0]  m_data_in;
  logic [7:0]  m_data_out = '0;
  logic        m_done = 1'b0;

  int total = 0;
  int passed = 0;

  i2c_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_done(m_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] mdata;
    int         delay;
    logic [3:0] exp_grant;
    logic       exp_rw;
    logic [7:0] exp_rsp;
  } vec_t;

  vec_t vecs[9];
  vec_t rrv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    m_done = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_m_start", {31'd0, m_start}, 32'd0);
    chk("reset_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("reset_m_addr", {25'd0, m_addr}, 32'd0);
    chk("reset_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
  endtask

  // One full transaction; called with the DUT idle at a sample point.
  task automatic run_txn(input vec_t v, input bit keep);
    req_valid = v.req;
    req_rw    = v.rw;
    req_addr  = {4{v.addr}};
    req_data  = {4{v.wdata}};
    #1;
    chk("grant", {28'd0, req_ready}, {28'd0, v.exp_grant});
    step();
    chk("issue_m_start", {31'd0, m_start}, 32'd1);
    chk("issue_m_addr", {25'd0, m_addr}, {25'd0, v.addr});
    chk("issue_m_rw", {31'd0, m_rw}, {31'd0, v.exp_rw});
    chk("issue_m_data_in", {24'd0, m_data_in}, {24'd0, v.wdata});
    if (!keep) req_valid = '0;
    #1;
    chk("issue_no_ready", {28'd0, req_ready}, 32'd0);
    step();
    chk("wait_m_start_low", {31'd0, m_start}, 32'd0);
    for (int k = 0; k < v.delay; k++) step();
    m_done = 1'b1;
    m_data_out = v.mdata;
    chk("wait_addr_held", {25'd0, m_addr}, {25'd0, v.addr});
    chk("wait_data_held", {24'd0, m_data_in}, {24'd0, v.wdata});
    step();
    m_done = 1'b0;
    chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, v.exp_grant});
    chk("rsp_data", {24'd0, rsp_data}, {24'd0, v.exp_rsp});
    chk("rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("rsp_m_start_low", {31'd0, m_start}, 32'd0);
    step();
    chk("rsp_cleared", {28'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit early;

    //          req    rw     addr   wdata  mdata  dly grant  rw    rsp
    vecs[0] = '{4'b0010, 4'b1111, 7'h2A, 8'hA5, 8'h77, 2, 4'b0010, 1'b1, 8'h00};
    vecs[1] = '{4'b0001, 4'b0000, 7'h11, 8'h00, 8'h3C, 1, 4'b0001, 1'b0, 8'h3C};
    vecs[2] = '{4'b1111, 4'b0000, 7'h20, 8'h01, 8'h5A, 0, 4'b0010, 1'b0, 8'h5A};
    vecs[3] = '{4'b1111, 4'b0100, 7'h21, 8'h02, 8'h66, 3, 4'b0100, 1'b1, 8'h00};
    vecs[4] = '{4'b1001, 4'b0000, 7'h22, 8'h03, 8'hC3, 0, 4'b1000, 1'b0, 8'hC3};
    vecs[5] = '{4'b1001, 4'b1000, 7'h23, 8'h04, 8'h99, 1, 4'b0001, 1'b0, 8'h99};
    vecs[6] = '{4'b0100, 4'b1011, 7'h24, 8'h05, 8'h12, 0, 4'b0100, 1'b0, 8'h12};
    vecs[7] = '{4'b1011, 4'b1000, 7'h25, 8'h06, 8'h34, 2, 4'b1000, 1'b1, 8'h00};
    vecs[8] = '{4'b0110, 4'b0100, 7'h26, 8'h07, 8'h56, 0, 4'b0010, 1'b0, 8'h56};

    do_reset();
    #1;
    chk("idle_no_ready", {28'd0, req_ready}, 32'd0);
    for (int i = 0; i < 9; i++) run_txn(vecs[i], 1'b0);

    // Continuous requests from all clients: order 0,1,2,3,0.
    do_reset();
    rrv = '{4'b1111, 4'b0000, 7'h40, 8'h10, 8'h81, 0, 4'b0001, 1'b0, 8'h81};
    for (int i = 0; i < 5; i++) begin
      rrv.exp_grant = 4'b0001 << (i % 4);
      run_txn(rrv, 1'b1);
    end
    req_valid = '0;

    // Watchdog expiry: 64 cycles after entering WAIT.
    do_reset();
    req_valid = 4'b0100; req_rw = 4'b0000; req_addr = {4{7'h33}};
    #1;
    chk("tmo_grant", {28'd0, req_ready}, 32'h4);
    step();
    req_valid = '0;
    step();
    early = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (k < TMO && rsp_valid != 4'b0000) early = 1'b1;
    end
    chk("tmo_no_early_rsp", {31'd0, early}, 32'd0);
    chk("tmo_rsp_valid", {28'd0, rsp_valid}, 32'h4);
    chk("tmo_flag", {31'd0, rsp_timeout}, 32'd1);
    chk("tmo_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("tmo_addr_held", {25'd0, m_addr}, 32'h33);
    step();
    chk("tmo_back_idle_rsp", {28'd0, rsp_valid}, 32'd0);
    chk("tmo_back_idle_flag", {31'd0, rsp_timeout}, 32'd0);

    // m_done on the expiry cycle wins over the watchdog.
    do_reset();
    req_valid = 4'b0100; req_rw = 4'b0000;
    #1;
    step();
    req_valid = '0;
    step();
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (k == TMO - 1) begin
        m_done = 1'b1;
        m_data_out = 8'hE7;
      end else begin
        m_done = 1'b0;
      end
    end
    chk("edge_rsp_valid", {28'd0, rsp_valid}, 32'h4);
    chk("edge_no_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("edge_rsp_data", {24'd0, rsp_data}, 32'hE7);
    step();

    // Reset during WAIT: no response, pointer back to client 0.
    do_reset();
    run_txn(vecs[0], 1'b0);
    req_valid = 4'b0100; req_addr = {4{7'h55}};
    #1;
    chk("rstmid_grant", {28'd0, req_ready}, 32'h4);
    step();
    req_valid = '0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_m_start", {31'd0, m_start}, 32'd0);
    chk("rstmid_m_addr", {25'd0, m_addr}, 32'd0);
    early = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid != 4'b0000) early = 1'b1;
      step();
    end
    chk("rstmid_no_rsp", {31'd0, early}, 32'd0);
    rrv = '{4'b0101, 4'b0000, 7'h0F, 8'h00, 8'h6D, 0, 4'b0001, 1'b0, 8'h6D};
    run_txn(rrv, 1'b0);

    // Spurious m_done in IDLE and in ISSUE is ignored.
    do_reset();
    m_done = 1'b1; m_data_out = 8'hFF;
    step();
    m_done = 1'b0;
    chk("spur_idle_rsp", {28'd0, rsp_valid}, 32'd0);
    chk("spur_idle_start", {31'd0, m_start}, 32'd0);
    step();
    chk("spur_idle_rsp2", {28'd0, rsp_valid}, 32'd0);
    req_valid = 4'b0001; req_rw = 4'b0000;
    #1;
    chk("spur_grant", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = '0;
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    chk("spur_issue_rsp", {28'd0, rsp_valid}, 32'd0);
    step();
    chk("spur_issue_rsp2", {28'd0, rsp_valid}, 32'd0);
    m_done = 1'b1; m_data_out = 8'h42;
    step();
    m_done = 1'b0;
    chk("spur_real_rsp", {28'd0, rsp_valid}, 32'h1);
    chk("spur_real_data", {24'd0, rsp_data}, 32'h42);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
